// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// word-wide ready-handshaked memory port and a flush-on-halt sweep.
module dcache_controller #(
    parameter int unsigned NUM_LINES       = 8,
    parameter int unsigned WORDS_PER_BLOCK = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        hit,
    input  logic        flush_req,
    output logic        flush_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;
    localparam int unsigned DEPTH = NUM_LINES * WORDS_PER_BLOCK;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_BLOCK - 1);
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_FLUSH_SCAN,
        S_FLUSH_WB
    } state_e;

    state_e           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] line_q, line_d;
    logic             flush_done_q, done_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0] tag_q [NUM_LINES];
    logic [31:0]      data_q [DEPTH];

    logic [OFF_W-1:0] word;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] wb_line;
    logic             req;
    logic             fill_beat, fill_last, wb_clear;
    logic             unused_addr_bits;

    assign word    = cpu_addr[2 +: OFF_W];
    assign idx     = cpu_addr[2 + OFF_W +: IDX_W];
    assign req_tag = cpu_addr[31 -: TAG_W];
    assign req     = cpu_read | cpu_write;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Flush sweeps walk their own line counter; CPU misses use the request index.
    assign wb_line = (state_q == S_FLUSH_SCAN || state_q == S_FLUSH_WB) ? line_q : idx;

    assign hit = req && (state_q == S_IDLE) && !flush_req && valid_q[idx]
                 && (tag_q[idx] == req_tag);
    assign cpu_rdata  = (hit && cpu_read) ? data_q[{idx, word}] : 32'h0;
    assign flush_done = flush_done_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            flush_done_q <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            flush_done_q <= done_d;
            if (fill_last) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (hit && cpu_write) begin
                dirty_q[idx] <= 1'b1;
            end
            if (wb_clear) begin
                dirty_q[line_q] <= 1'b0;
            end
        end
    end

    // Data and tag arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_q[{idx, cnt_q}] <= mem_rdata;
        end
        if (hit && cpu_write) begin
            data_q[{idx, word}] <= cpu_wdata;
        end
        if (fill_last) begin
            tag_q[idx] <= req_tag;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        done_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        fill_beat = 1'b0;
        fill_last = 1'b0;
        wb_clear  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH_SCAN;
                    line_d  = '0;
                end else if (req && !hit) begin
                    cnt_d   = '0;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[wb_line], wb_line, cnt_q, 2'b00};
                mem_wdata = data_q[{wb_line, cnt_q}];
                if (mem_ready) begin
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                mem_read = 1'b1;
                mem_addr = {req_tag, idx, cnt_q, 2'b00};
                if (mem_ready) begin
                    fill_beat = 1'b1;
                    cnt_d     = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        fill_last = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_FLUSH_SCAN: begin
                if (dirty_q[line_q]) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH_WB;
                end else if (line_q == LAST_LINE) begin
                    line_d  = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    line_d = line_q + IDX_W'(1);
                end
            end
            S_FLUSH_WB: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[wb_line], wb_line, cnt_q, 2'b00};
                mem_wdata = data_q[{wb_line, cnt_q}];
                if (mem_ready) begin
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d    = '0;
                        wb_clear = 1'b1;
                        if (line_q == LAST_LINE) begin
                            line_d  = '0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            line_d  = line_q + IDX_W'(1);
                            state_d = S_FLUSH_SCAN;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios plus random traffic checked
// against an architectural memory image and a tag/valid/dirty cache model.
module tb_dcache_controller;

    localparam int NL = 8;
    localparam int WPB = 4;
    localparam int LINE_BYTES = WPB * 4;
    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0] cpu_rdata;
    logic        hit;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    dcache_controller #(.NUM_LINES(NL), .WORDS_PER_BLOCK(WPB)) dut (
        .clk(clk), .rst_b(rst_b),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .hit(hit),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem_arr [MEM_WORDS];
    logic [31:0] golden [MEM_WORDS];
    bit          m_valid [NL];
    bit          m_dirty [NL];
    int          m_tag [NL];
    beat_t       log_q[$];
    beat_t       exp_q[$];

    int          lat_cfg = 2;
    int          cur_lat = 1;
    int          wait_cnt = 0;
    logic [31:0] beat_a, beat_d;
    logic        beat_w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory slave: random or fixed ready latency, one idle cycle between beats.
    always @(negedge clk) begin
        if (!rst_b) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else if (mem_read || mem_write) begin
            check("rw_exclusive", 64'(mem_read & mem_write), 64'(0));
            if (wait_cnt == 0) begin
                beat_a  = mem_addr;
                beat_d  = mem_wdata;
                beat_w  = mem_write;
                cur_lat = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 3));
            end else begin
                check("stable_addr", 64'(mem_addr), 64'(beat_a));
                check("stable_wdata", 64'(mem_wdata), 64'(beat_d));
                check("stable_write", 64'(mem_write), 64'(beat_w));
            end
            if (wait_cnt >= cur_lat) begin
                mem_ready = 1'b1;
                if (mem_write) mem_arr[mem_addr[11:2]] = mem_wdata;
                else           mem_rdata = mem_arr[mem_addr[11:2]];
                log_q.push_back({mem_write, mem_addr,
                                 mem_write ? mem_wdata : mem_arr[mem_addr[11:2]]});
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic compare_beats(input string tag);
        int n;
        check({tag, "_beats"}, 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_beat_w"}, 64'(log_q[i].w), 64'(exp_q[i].w));
            check({tag, "_beat_a"}, 64'(log_q[i].a), 64'(exp_q[i].a));
            check({tag, "_beat_d"}, 64'(log_q[i].d), 64'(exp_q[i].d));
        end
    endtask

    task automatic push_line(input bit w, input int line_no);
        for (int b = 0; b < WPB; b++) begin
            exp_q.push_back({w, 32'(line_no * LINE_BYTES + 4 * b),
                             golden[line_no * WPB + b]});
        end
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd);
        int  ln, idx, tg, cyc;
        bit  miss;
        ln   = int'(a) / LINE_BYTES;
        idx  = ln % NL;
        tg   = ln / NL;
        miss = !(m_valid[idx] && m_tag[idx] == tg);
        exp_q.delete();
        log_q.delete();
        if (miss) begin
            if (m_valid[idx] && m_dirty[idx]) push_line(1'b1, m_tag[idx] * NL + idx);
            push_line(1'b0, ln);
        end
        @(posedge clk); #1;
        cpu_addr = a; cpu_wdata = wd; cpu_read = rd; cpu_write = wr;
        @(negedge clk);
        check("hit_first", 64'(hit), 64'(!miss));
        cyc = 0;
        while (!hit && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("hit_seen", 64'(hit), 64'(1));
        if (rd) check("rdata", 64'(cpu_rdata), 64'(golden[a[11:2]]));
        else    check("rdata_zero", 64'(cpu_rdata), 64'(0));
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        compare_beats("acc");
        if (miss) begin
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        if (wr) begin
            golden[a[11:2]] = wd;
            m_dirty[idx]    = 1'b1;
        end
    endtask

    task automatic do_flush(input bit expect_clean);
        int cyc, pulses;
        exp_q.delete();
        log_q.delete();
        for (int i = 0; i < NL; i++) begin
            if (m_valid[i] && m_dirty[i]) push_line(1'b1, m_tag[i] * NL + i);
        end
        @(posedge clk); #1;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        cyc = 0;
        pulses = 0;
        while (!flush_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("flush_done_seen", 64'(flush_done), 64'(1));
        if (expect_clean) check("flush_scan_cycles", 64'(cyc), 64'(NL + 1));
        for (int k = 0; k < 4; k++) begin
            if (flush_done) pulses++;
            @(negedge clk);
        end
        check("flush_done_pulses", 64'(pulses), 64'(1));
        compare_beats("flush");
        for (int i = 0; i < NL; i++) m_dirty[i] = 1'b0;
    endtask

    task automatic cpu_op(input int op, input logic [31:0] a, input logic [31:0] wd);
        case (op)
            0:       do_access(1'b1, 1'b0, a, wd);
            1:       do_access(1'b0, 1'b1, a, wd);
            default: do_access(1'b1, 1'b1, a, wd);
        endcase
    endtask

    initial begin
        int mism, cyc;
        for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = 32'hA000_0000 | 32'(i);
        for (int b = 0; b < WPB; b++) mem_arr[16 + b] = 32'h100 + 32'(b);
        for (int i = 0; i < MEM_WORDS; i++) golden[i] = mem_arr[i];
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 0;
        end

        #12;
        check("rst_hit", 64'(hit), 64'(0));
        check("rst_mem_read", 64'(mem_read), 64'(0));
        check("rst_mem_write", 64'(mem_write), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_flush_done", 64'(flush_done), 64'(0));
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        @(negedge clk);
        rst_b = 1'b1;

        // Cold miss, hit, write, dirty eviction.
        lat_cfg = 2;
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        do_access(1'b1, 1'b0, 32'h48, 32'h0);
        do_access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h244, 32'h0);

        // Stretched handshake through an eviction and refill.
        do_access(1'b0, 1'b1, 32'h240, 32'h1234_5678);
        lat_cfg = 5;
        do_access(1'b1, 1'b0, 32'h440, 32'h0);
        lat_cfg = 2;

        // Flush with lines 1 and 5 dirty, then a clean flush.
        do_access(1'b0, 1'b1, 32'h10, 32'h1111_0001);
        do_access(1'b0, 1'b1, 32'h54, 32'h5555_0005);
        do_flush(1'b0);
        do_flush(1'b1);

        // Asynchronous reset in the middle of a refill.
        log_q.delete();
        @(posedge clk); #1;
        cpu_addr = 32'h600; cpu_read = 1'b1;
        cyc = 0;
        while (log_q.size() < 2 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_b = 1'b0;
        #1;
        check("midrst_mem_read", 64'(mem_read), 64'(0));
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check("midrst_hit", 64'(hit), 64'(0));
        cpu_read = 1'b0;
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        for (int i = 0; i < MEM_WORDS; i++) golden[i] = mem_arr[i];
        @(negedge clk);
        rst_b = 1'b1;
        do_access(1'b1, 1'b0, 32'h600, 32'h0);

        // Simultaneous read and write on a hit.
        do_access(1'b1, 1'b0, 32'h48, 32'h0);
        do_access(1'b1, 1'b1, 32'h48, 32'h5A5A_5A5A);
        do_access(1'b1, 1'b0, 32'h48, 32'h0);
        do_flush(1'b0);

        // Random traffic.
        lat_cfg = 0;
        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            a = {20'h0, 10'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
            if ($urandom_range(0, 19) == 0) do_flush(1'b0);
            else cpu_op(int'($urandom_range(0, 2)), a, $urandom);
        end
        do_flush(1'b0);

        mism = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem_arr[i] !== golden[i]) mism++;
        check("memory_coherent", 64'(mism), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
